// File: rtl/branch_flush_unit_pkg.sv
// Shared types and counter helpers for the branch predictor:
// the 2-bit saturating counter encoding and its update/prediction functions.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = WNT;

  // Saturating step toward the observed outcome
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

  function automatic logic ctr_pred(input bht_ctr_t ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/branch_flush_unit_bht_ram.sv
// Branch history table: one asynchronous read port for fetch and one
// synchronous read-modify-write update port; every entry resets to WNT.
module bht_ram
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output bht_ctr_t              rd_ctr,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bht_ctr_t mem [ENTRIES];

  // Fetch sees the stored value only; an update in the same cycle lands after the edge
  assign rd_ctr = mem[rd_idx];

  // Counter array with asynchronous clear of every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      mem[upd_idx] <= ctr_next(mem[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_flush_unit.sv
// Branch predictor front end plus misprediction flush generator: predicts at
// fetch, resolves in EX, and emits a one-cycle flush pulse with redirect PC.
module branch_flush_unit
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_BF,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_is_branch,
  input  logic [XLEN-1:0] fetch_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            rst_out,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4'd4);
  localparam logic [31:0]     COUNT_MAX = 32'hFFFF_FFFF;

  bht_ctr_t  fetch_ctr;
  logic      accepted;
  logic      mispredict;
  logic [XLEN-1:0] correct_pc;

  bht_ram #(
    .INDEX_BITS (INDEX_BITS)
  ) u_bht (
    .clk       (clk),
    .rst       (rst_BF),
    .rd_idx    (fetch_pc[INDEX_BITS+1:2]),
    .rd_ctr    (fetch_ctr),
    .upd_en    (accepted),
    .upd_idx   (ex_pc[INDEX_BITS+1:2]),
    .upd_taken (ex_taken)
  );

  assign pred_taken = fetch_is_branch & ctr_pred(fetch_ctr);
  assign pred_pc    = pred_taken ? fetch_target : (fetch_pc + PC_STEP);

  // A resolution arriving while the flush is high belongs to the squashed path
  assign accepted   = ex_valid & ~rst_out;
  assign mispredict = accepted & (ex_taken != ex_pred_taken);
  assign correct_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);

  // Flush pulse, redirect target and saturating performance counters
  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      rst_out          <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      rst_out <= mispredict;
      if (mispredict) begin
        redirect_pc <= correct_pc;
        if (mispredict_count != COUNT_MAX) begin
          mispredict_count <= mispredict_count + 32'd1;
        end
      end
      if (accepted && (branch_count != COUNT_MAX)) begin
        branch_count <= branch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_flush_unit.sv
// Directed bench for branch_flush_unit: stimulus pushes expected flush events
// into a queue, and a negedge monitor pops and compares on every rst_out pulse.
module tb_branch_flush_unit;

  localparam int XLEN       = 32;
  localparam int INDEX_BITS = 6;

  logic            clk = 1'b0;
  logic            rst_BF;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_is_branch;
  logic [XLEN-1:0] fetch_target;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            rst_out;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  typedef struct packed {
    logic [31:0] redir;
    logic [31:0] mcnt;
    logic [31:0] bcnt;
  } flush_exp_t;

  flush_exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int exp_b = 0;
  int exp_m = 0;

  branch_flush_unit #(.INDEX_BITS(INDEX_BITS), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst_BF           (rst_BF),
    .fetch_pc         (fetch_pc),
    .fetch_is_branch  (fetch_is_branch),
    .fetch_target     (fetch_target),
    .pred_taken       (pred_taken),
    .pred_pc          (pred_pc),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .rst_out          (rst_out),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every flush pulse must match the oldest queued expectation
  always @(negedge clk) begin
    flush_exp_t e;
    if (rst_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_flush: rst_out=1 redirect_pc=%h, want no pulse", redirect_pc);
      end else begin
        e = exp_q.pop_front();
        check("redirect_pc", redirect_pc, e.redir);
        check("mispredict_count_at_flush", mispredict_count, e.mcnt);
        check("branch_count_at_flush", branch_count, e.bcnt);
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [31:0] pc, input logic isb, input logic [31:0] tgt,
                         input logic exp_taken, input string name);
    fetch_pc        = pc;
    fetch_is_branch = isb;
    fetch_target    = tgt;
    #1;
    check({name, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    check({name, "_pred_pc"}, pred_pc, exp_taken ? tgt : pc + 32'd4);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic pt, input logic squashed);
    flush_exp_t e;
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_taken      = taken;
    ex_target     = tgt;
    ex_pred_taken = pt;
    if (!squashed) begin
      exp_b++;
      if (taken != pt) begin
        exp_m++;
        e.redir = taken ? tgt : pc + 32'd4;
        e.mcnt  = 32'(exp_m);
        e.bcnt  = 32'(exp_b);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_BF = 1'b1;
    fetch_pc = 32'd0; fetch_is_branch = 1'b0; fetch_target = 32'd0;
    ex_valid = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0; ex_target = 32'd0; ex_pred_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_BF = 1'b0;
    check("reset_rst_out", {31'd0, rst_out}, 32'd0);
    check("reset_branch_count", branch_count, 32'd0);
    check("reset_mispredict_count", mispredict_count, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    predict(32'h100, 1'b1, 32'h800, 1'b0, "reset_0x100");
    predict(32'h3C, 1'b1, 32'h500, 1'b0, "reset_0x3c");
    idle();

    // Training: WNT -> WT (mispredict) -> ST -> ST
    resolve(32'h100, 1'b1, 32'h800, 1'b0, 1'b0);
    idle();
    predict(32'h100, 1'b1, 32'h800, 1'b1, "train1");
    resolve(32'h100, 1'b1, 32'h800, 1'b1, 1'b0);
    resolve(32'h100, 1'b1, 32'h800, 1'b1, 1'b0);
    check("train_branch_count", branch_count, 32'd3);
    check("train_mispredict_count", mispredict_count, 32'd1);

    // Hysteresis: ST -> WT still taken, WT -> WNT not taken
    resolve(32'h100, 1'b0, 32'h800, 1'b1, 1'b0);
    idle();
    predict(32'h100, 1'b1, 32'h800, 1'b1, "hyst_wt");
    resolve(32'h100, 1'b0, 32'h800, 1'b1, 1'b0);
    idle();
    predict(32'h100, 1'b1, 32'h800, 1'b0, "hyst_wnt");

    // Aliasing: 0x100 and 0x200 share index 0
    resolve(32'h100, 1'b1, 32'h900, 1'b0, 1'b0);
    idle();
    predict(32'h200, 1'b1, 32'h300, 1'b1, "alias");

    // Same-cycle fetch/update of index 0 returns the old counter
    predict(32'h200, 1'b1, 32'h300, 1'b1, "same_cycle_old");
    resolve(32'h100, 1'b0, 32'h900, 1'b1, 1'b0);
    predict(32'h200, 1'b1, 32'h300, 1'b0, "same_cycle_after");
    idle();

    // Squash: second resolution lands in the flush cycle and is ignored
    resolve(32'h140, 1'b1, 32'hA00, 1'b0, 1'b0);
    resolve(32'h2C0, 1'b1, 32'hB00, 1'b0, 1'b1);
    idle();
    predict(32'h2C0, 1'b1, 32'hB00, 1'b0, "squash_unchanged");
    predict(32'h140, 1'b1, 32'hA00, 1'b1, "squash_first");
    check("squash_branch_count", branch_count, 32'd8);
    check("squash_mispredict_count", mispredict_count, 32'd6);
    idle();

    // PC+4 wraps to zero
    resolve(32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 1'b0);
    idle();
    predict(32'hFFFF_FFFC, 1'b0, 32'h40, 1'b0, "wrap_nonbranch");
    predict(32'h140, 1'b0, 32'hA00, 1'b0, "nonbranch_trained");
    idle();

    // Reset asserted while the flush is high
    ex_valid = 1'b1; ex_pc = 32'h140; ex_taken = 1'b0; ex_target = 32'hA00; ex_pred_taken = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    check("midflush_rst_out_high", {31'd0, rst_out}, 32'd1);
    #1;
    rst_BF = 1'b1;
    #1;
    check("midflush_rst_out_dropped", {31'd0, rst_out}, 32'd0);
    check("midflush_branch_count", branch_count, 32'd0);
    check("midflush_mispredict_count", mispredict_count, 32'd0);
    @(posedge clk);
    #1;
    rst_BF = 1'b0;
    exp_b = 0;
    exp_m = 0;
    predict(32'h140, 1'b1, 32'hA00, 1'b0, "post_reset_0x140");
    idle();
    resolve(32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 1'b0);
    idle();
    predict(32'hFFFF_FFFC, 1'b1, 32'h40, 1'b1, "post_reset_wnt");
    check("post_reset_branch_count", branch_count, 32'd1);
    check("post_reset_mispredict_count", mispredict_count, 32'd1);

    idle();
    idle();
    check("pending_flushes", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_flush_unit.md
# branch_flush_unit

Dynamic branch predictor and misprediction flush generator for the pipelined RISC-V core. It predicts conditional branches at fetch from a table of 2-bit saturating counters. It resolves each branch in EX against its prediction and drives the one-cycle `rst_out` flush pulse plus the redirect PC. It also keeps branch and misprediction counters, which the application testbenches sample and log.

## Interface
- `INDEX_BITS`, 6, log2 of BHT entries (64 entries)
- `XLEN`, 32, PC/data width
- `clk` in 1, core clock, all state on rising edge
- `rst_BF` in 1, asynchronous active-high reset
- `fetch_pc` in XLEN, PC of instruction in IF
- `fetch_is_branch` in 1, predecode: IF holds a conditional branch
- `fetch_target` in XLEN, predecoded branch target
- `pred_taken` out 1, combinational prediction for IF
- `pred_pc` out XLEN, combinational next PC: `fetch_target` if predicted taken, else `fetch_pc+4`
- `ex_valid` in 1, a conditional branch resolves in EX this cycle
- `ex_pc` in XLEN, PC of resolving branch
- `ex_taken` in 1, actual outcome
- `ex_target` in XLEN, actual target
- `ex_pred_taken` in 1, prediction carried down the pipe with the branch
- `rst_out` out 1, registered flush pulse to IF/ID/EX pipeline registers
- `redirect_pc` out XLEN, registered correct PC, valid while `rst_out`=1
- `branch_count` out 32, resolved branches
- `mispredict_count` out 32, mispredictions (equals `rst_out` pulses)

## Operation
- BHT: 2^INDEX_BITS counters. Index = `pc[INDEX_BITS+1:2]`. No tags; aliasing is allowed.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Prediction = counter MSB.
- `pred_taken` = `fetch_is_branch` & MSB(BHT[idx(fetch_pc)]). It is 0 when `fetch_is_branch`=0.
- Accepted resolution = `ex_valid` & !`rst_out`. An `ex_valid` during the cycle `rst_out`=1 is wrong-path work. It is ignored: no BHT update, no count, no flush.
- On accepted resolution:
  - BHT[idx(ex_pc)] increments if `ex_taken`, otherwise decrements.
  - The counter saturates at 11 and 00.
  - `branch_count`++.
- Mispredict = accepted & (`ex_taken` != `ex_pred_taken`). On mispredict, next cycle:
  - `rst_out`=1.
  - `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc+4`.
  - `mispredict_count`++ (updated in the same edge as `rst_out` rises).
- Correctly predicted taken branches with a wrong target are not checked; the target comes from predecode and is exact.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Same cycle fetch read and EX update to the same index: the prediction uses the pre-update counter. There is no bypass.
- PC+4 wraps modulo 2^XLEN.

## Timing
- Prediction: zero latency, combinational from `fetch_pc` and the BHT.
- Resolution to flush: 1 cycle. `rst_out` is high for exactly one cycle per mispredict.
- Back-to-back mispredicts are impossible by construction, because the cycle after a flush is squashed. Minimum spacing between `rst_out` pulses is 2 cycles.
- BHT update is visible to fetch reads from the cycle after the resolving edge.
- Reset values while `rst_BF`=1:
  - all BHT entries = WNT (01)
  - `rst_out`=0
  - `redirect_pc`=0
  - `branch_count`=0
  - `mispredict_count`=0
- Reset asserted mid-flush clears `rst_out` immediately (asynchronously). Any pending update is lost.
- First accepted resolution is sampled on the first rising edge after `rst_BF` deasserts.

## Structure
- Package `bp_pkg`:
  - `bht_ctr_t` 2-bit enum (SNT/WNT/WT/ST)
  - `BHT_RESET` = WNT
  - functions `ctr_next(ctr, taken)` and `ctr_pred(ctr)`
- One natural sub-module: `bht_ram`, the counter array with one async read port, one sync write port and async reset of all entries.
- Top level holds the flush register, redirect register and perf counters.

## Test plan
- Reset:
  - hold `rst_BF` 3 cycles, then release.
  - Required: `rst_out`=0, both counts 0.
  - Required: `pred_taken`=1? No. With `fetch_is_branch`=1 at any PC, `pred_taken`=0 (WNT).
- Training:
  - Resolve PC 0x100 taken 3 times with `ex_pred_taken` copied from `pred_taken`.
  - Required: 1st resolution mispredicts, `rst_out` pulse, `redirect_pc`=target.
  - Required: 2nd and 3rd resolutions are correct; counter reaches ST.
  - Required: `branch_count`=3, `mispredict_count`=1.
- Saturation and hysteresis: from ST, resolve not-taken once.
  - Required: counter = WT, prediction still taken.
  - Required: `redirect_pc`=0x104, `mispredict_count`+1.
- Squash: mispredict at cycle N, `ex_valid`=1 with a mismatch at cycle N+1.
  - Required: single `rst_out` pulse.
  - Required: counts incremented once, BHT entry of the second PC unchanged.
- Aliasing and same-cycle read: PCs 0x100 and 0x200 share an index (INDEX_BITS=6).
  - Train 0x100 taken; 0x200 then predicts taken.
  - Fetch and update the same index in one cycle; required: old value is returned.
- Reset mid-flush: assert `rst_BF` asynchronously while `rst_out`=1.
  - Required: `rst_out` drops before the next edge.
  - Required: counts are 0 and all BHT entries are WNT.
